// File: rtl/deskew_reorder_rx.sv
// rtl/deskew_reorder_rx.sv - multi-lane block deskew on alignment markers with optional lane reorder
// Purpose: buffers each physical lane from its first alignment marker, then releases all lanes
//   together once every lane has shown a marker, presenting marker-aligned blocks on each
//   logical lane. Markers arriving on some but not all lanes while aligned drop the alignment.
// Ports:
//   clk, reset          - sole clock (rising edge), synchronous active-high reset
//   valid_i[LANE_N]     - per-physical-lane block valid (must be all-ones or all-zeros)
//   am_v_i[LANE_N]      - alignment marker present on the lane this cycle
//   lock_v_i[LANE_N]    - upstream block/marker lock per lane
//   lane_id_i           - logical lane number decoded from the marker, ID_W bits per lane
//   data_i              - physical lane blocks, lane p at [p*BLOCK_W +: BLOCK_W]
//   valid_o, am_v_o     - aligned block valid / aligned markers on all output lanes
//   data_o              - deskewed blocks, logical lane k at [k*BLOCK_W +: BLOCK_W]
//   deskew_lock_o       - high while aligned
//   skew_err_o          - one-cycle pulse, skew exceeded MAX_SKEW_BLOCK_N
//   align_err_o         - one-cycle pulse, duplicate lane id or marker misalignment while locked
// Optional feature macro: LANE_REORDER_EN (logical lane k is taken from the physical lane whose
//   captured marker id equals k; otherwise the mapping is identity and lane_id_i is unused).
module deskew_reorder_rx #(
  parameter int  LANE_N           = 4,
  parameter int  BLOCK_W          = 66,
  parameter int  MAX_SKEW_BLOCK_N = 8,
  localparam int ID_W             = (LANE_N > 1) ? $clog2(LANE_N) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANE_N-1:0]         valid_i,
  input  logic [LANE_N-1:0]         am_v_i,
  input  logic [LANE_N-1:0]         lock_v_i,
  input  logic [LANE_N*ID_W-1:0]    lane_id_i,
  input  logic [LANE_N*BLOCK_W-1:0] data_i,
  output logic                      valid_o,
  output logic                      am_v_o,
  output logic [LANE_N*BLOCK_W-1:0] data_o,
  output logic                      deskew_lock_o,
  output logic                      skew_err_o,
  output logic                      align_err_o
);
  localparam int DEPTH = MAX_SKEW_BLOCK_N + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_AM, ALIGNED} state_t;
  state_t state, state_next;

  // Each entry is {marker flag, block}.
  logic [BLOCK_W:0]          lane_buf [LANE_N][DEPTH];
  logic [PTR_W-1:0]          wptr [LANE_N];
  logic [PTR_W-1:0]          rptr;
  logic [CNT_W-1:0]          skew_cnt;
  logic [LANE_N-1:0]         seen;

  logic                      all_valid, lock_loss, in_wait, in_aligned;
  logic [LANE_N-1:0]         new_mark, seen_next, rd_flag;
  logic                      skew_over, dup_id, final_mark, flag_all, flag_mix;
  logic                      ev_skew, ev_dup, ev_lock, ev_mis, ev_out, clear_all;
  logic [BLOCK_W:0]          rd_entry [LANE_N];
  logic [ID_W-1:0]           id_next [LANE_N];
  logic [LANE_N*BLOCK_W-1:0] mux_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign all_valid  = &valid_i;
  // A partial valid pattern means the lanes have lost block alignment to each other.
  assign lock_loss  = ~&lock_v_i | ~(all_valid | ~|valid_i);
  assign in_wait    = (state == WAIT_AM);
  assign in_aligned = (state == ALIGNED);

  // The counter equals the number of valid cycles since the first marker; once it reaches
  // DEPTH the earliest lane would overwrite its marker, so later markers are too late.
  assign skew_over  = (|seen) && (skew_cnt == CNT_LIMIT);
  assign new_mark   = (in_wait && all_valid && !skew_over) ? (am_v_i & ~seen) : '0;
  assign seen_next  = seen | new_mark;
  assign final_mark = in_wait & all_valid & ~skew_over & (&seen_next);

`ifdef LANE_REORDER_EN
  logic [ID_W-1:0] id_q [LANE_N];

  always_comb begin
    for (int p = 0; p < LANE_N; p++)
      id_next[p] = new_mark[p] ? lane_id_i[p*ID_W +: ID_W] : id_q[p];
    dup_id = 1'b0;
    for (int p = 0; p < LANE_N; p++)
      for (int q = p + 1; q < LANE_N; q++)
        if (id_next[p] == id_next[q]) dup_id = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      for (int p = 0; p < LANE_N; p++) id_q[p] <= '0;
    end else if (in_wait && all_valid) begin
      for (int p = 0; p < LANE_N; p++) id_q[p] <= id_next[p];
    end
  end
`else
  logic unused_lane_id;
  assign unused_lane_id = ^lane_id_i;
  assign dup_id = 1'b0;
  for (genvar g = 0; g < LANE_N; g++) begin : g_id_identity
    assign id_next[g] = ID_W'(g);
  end
`endif

  // The entry being written this cycle is forwarded, so the slowest lane (and every lane in
  // the final-marker cycle) is read without waiting for the buffer write.
  always_comb begin
    for (int p = 0; p < LANE_N; p++) begin
      rd_entry[p] = (wptr[p] == rptr) ? {am_v_i[p], data_i[p*BLOCK_W +: BLOCK_W]}
                                      : lane_buf[p][rptr];
      rd_flag[p]  = rd_entry[p][BLOCK_W];
    end
    flag_all = &rd_flag;
    flag_mix = (|rd_flag) & ~flag_all;
    mux_data = '0;
    for (int k = 0; k < LANE_N; k++)
      for (int p = 0; p < LANE_N; p++)
        if (id_next[p] == ID_W'(k)) mux_data[k*BLOCK_W +: BLOCK_W] = rd_entry[p][BLOCK_W-1:0];
  end

  assign ev_skew   = in_wait & all_valid & skew_over & ~lock_loss;
  assign ev_dup    = final_mark & dup_id & ~lock_loss;
  assign ev_lock   = final_mark & ~dup_id & ~lock_loss;
  assign ev_mis    = in_aligned & all_valid & flag_mix & ~lock_loss;
  assign ev_out    = ev_lock | (in_aligned & all_valid & ~flag_mix & ~lock_loss);
  assign clear_all = (state == IDLE) | lock_loss | ev_skew | ev_dup | ev_mis;

  assign deskew_lock_o = in_aligned;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (&lock_v_i) state_next = WAIT_AM;
      WAIT_AM: if (ev_lock)   state_next = ALIGNED;
      ALIGNED: if (ev_mis)    state_next = WAIT_AM;
      default:                state_next = IDLE;
    endcase
    if (lock_loss) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen        <= '0;
      skew_cnt    <= '0;
      rptr        <= '0;
      for (int p = 0; p < LANE_N; p++) wptr[p] <= '0;
      valid_o     <= 1'b0;
      am_v_o      <= 1'b0;
      data_o      <= '0;
      skew_err_o  <= 1'b0;
      align_err_o <= 1'b0;
    end else begin
      valid_o     <= ev_out;
      am_v_o      <= ev_out & flag_all;
      skew_err_o  <= ev_skew;
      align_err_o <= ev_dup | ev_mis;
      if (ev_out) data_o <= mux_data;

      if (clear_all) begin
        seen     <= '0;
        skew_cnt <= '0;
        rptr     <= '0;
        for (int p = 0; p < LANE_N; p++) wptr[p] <= '0;
      end else if (in_wait && all_valid) begin
        seen <= seen_next;
        if (|seen_next) skew_cnt <= skew_cnt + CNT_W'(1);
        for (int p = 0; p < LANE_N; p++)
          if (seen_next[p]) wptr[p] <= ptr_inc(wptr[p]);
        if (ev_lock) rptr <= ptr_inc(rptr);
      end else if (in_aligned && all_valid) begin
        for (int p = 0; p < LANE_N; p++) wptr[p] <= ptr_inc(wptr[p]);
        rptr <= ptr_inc(rptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < LANE_N; p++)
      if (all_valid && ((in_wait && seen_next[p]) || in_aligned))
        lane_buf[p][wptr[p]] <= {am_v_i[p], data_i[p*BLOCK_W +: BLOCK_W]};
  end

endmodule

// File: tb/tb_deskew_reorder_rx.sv
// tb/tb_deskew_reorder_rx.sv - randomized scoreboard bench for deskew_reorder_rx
module tb_deskew_reorder_rx;
  localparam int LANE_N  = 4;
  localparam int BLOCK_W = 66;
  localparam int MAXS    = 8;
  localparam int ID_W    = 2;
  localparam int DW      = LANE_N * BLOCK_W;
  localparam int MLEN    = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [LANE_N-1:0] valid_i, am_v_i, lock_v_i;
  logic [LANE_N*ID_W-1:0] lane_id_i;
  logic [DW-1:0]     data_i, data_o;
  logic              valid_o, am_v_o, deskew_lock_o, skew_err_o, align_err_o;

  deskew_reorder_rx #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .MAX_SKEW_BLOCK_N(MAXS)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .am_v_i(am_v_i), .lock_v_i(lock_v_i),
    .lane_id_i(lane_id_i), .data_i(data_i), .valid_o(valid_o), .am_v_o(am_v_o),
    .data_o(data_o), .deskew_lock_o(deskew_lock_o), .skew_err_o(skew_err_o),
    .align_err_o(align_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          am;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   skew_pulses = 0;
  int   align_pulses = 0;
  int   sk  [LANE_N];
  int   ids [LANE_N];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BLOCK_W-1:0] rnd_blk();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[BLOCK_W-1:0];
  endfunction

  // Monitor: pops the scoreboard on every output block and counts error pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (skew_err_o)  skew_pulses++;
      if (align_err_o) align_pulses++;
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid_o", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("data_o", data_o, mon_e.data);
          check("am_v_o", am_v_o, mon_e.am);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [LANE_N-1:0] v, input logic [LANE_N-1:0] lk);
    valid_i  = v;
    lock_v_i = lk;
    am_v_i   = '0;
    for (int p = 0; p < LANE_N; p++) data_i[p*BLOCK_W +: BLOCK_W] = rnd_blk();
  endtask

  // Each logical lane carries a block stream with markers at every 16th block; physical lane p
  // carries logical lane ids[p] delayed by sk[p] valid cycles. The deskewed output is block j of
  // every logical lane, for each j the slowest lane has delivered, unless alignment fails.
  task automatic scenario(input int nvalid, input bit gaps, input int inj_j,
                          input bit lat_chk, input bit skew_chk, input int exp_skew,
                          input int exp_align, input bit exp_lock, input int end_kind);
    logic [BLOCK_W-1:0] blk [LANE_N][MLEN];
    logic [DW-1:0] word, last_word;
    int   smax, nout, v, j;
    bit   distinct;
    exp_t e;

    smax = 0;
    for (int p = 0; p < LANE_N; p++) if (sk[p] > smax) smax = sk[p];
    distinct = 1'b1;
    for (int p = 0; p < LANE_N; p++)
      for (int q = p + 1; q < LANE_N; q++)
        if (ids[p] == ids[q]) distinct = 1'b0;
    for (int k = 0; k < LANE_N; k++)
      for (int jj = 0; jj < MLEN; jj++) blk[k][jj] = rnd_blk();

    nout = nvalid - smax;
    if (inj_j >= 0 && inj_j < nout) nout = inj_j;
    if (smax > MAXS) nout = 0;
`ifdef LANE_REORDER_EN
    if (!distinct) nout = 0;
`endif
    if (nout < 0) nout = 0;
    last_word = '0;
    for (int jj = 0; jj < nout; jj++) begin
      for (int k = 0; k < LANE_N; k++) word[k*BLOCK_W +: BLOCK_W] = blk[k][jj];
      e.data = word;
      e.am   = (jj % 16 == 0);
      exp_q.push_back(e);
      last_word = word;
    end

    skew_pulses  = 0;
    align_pulses = 0;
    step();
    drive('0, '1);
    v = 0;
    while (v < nvalid) begin
      step();
      if (lat_chk && v == smax) check("lock_before_final_marker", deskew_lock_o, 0);
      if (lat_chk && v == smax + 1) begin
        check("lock_after_final_marker", deskew_lock_o, 1);
        check("first_valid_o", valid_o, 1);
        check("first_am_v_o", am_v_o, 1);
      end
      if (skew_chk && v == MAXS + 1) check("skew_err_early", skew_err_o, 0);
      if (skew_chk && v == MAXS + 2) check("skew_err_pulse", skew_err_o, 1);
      if (gaps && $urandom_range(3, 0) == 0) begin
        drive('0, '1);
      end else begin
        drive('1, '1);
        for (int p = 0; p < LANE_N; p++) begin
          j = v - sk[p];
          lane_id_i[p*ID_W +: ID_W] = ID_W'(ids[p]);
          if (j >= 0) begin
            data_i[p*BLOCK_W +: BLOCK_W] = blk[ids[p]][j];
            am_v_i[p] = (j % 16 == 0) || (p == 3 && j == inj_j);
          end
        end
        v++;
      end
    end
    repeat (2) begin
      step();
      drive('0, '1);
    end
    step();
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    check("skew_err_count", skew_pulses, exp_skew);
    check("align_err_count", align_pulses, exp_align);
    check("deskew_lock_o", deskew_lock_o, exp_lock);
    check("valid_o_idle", valid_o, 0);
    if (nout > 0) check("data_o_hold", data_o, last_word);

    case (end_kind)
      0: drive('1, 4'b1011);
      1: drive(4'b0101, '1);
      default: begin
        drive('1, '1);
        reset = 1'b1;
      end
    endcase
    step();
    reset = 1'b0;
    drive('0, '1);
    check("lock_after_exit", deskew_lock_o, 0);
    check("valid_after_exit", valid_o, 0);
    if (end_kind == 2) begin
      check("data_o_after_reset", data_o, 0);
      check("am_v_o_after_reset", am_v_o, 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    valid_i   = '0;
    am_v_i    = '0;
    lock_v_i  = '0;
    lane_id_i = '0;
    data_i    = '0;
    repeat (3) @(negedge clk);
    step();
    check("reset_valid_o", valid_o, 0);
    check("reset_am_v_o", am_v_o, 0);
    check("reset_data_o", data_o, 0);
    check("reset_deskew_lock_o", deskew_lock_o, 0);
    check("reset_skew_err_o", skew_err_o, 0);
    check("reset_align_err_o", align_err_o, 0);
    reset = 1'b0;

`ifdef LANE_REORDER_EN
    ids = '{2, 0, 3, 1};
`else
    ids = '{0, 1, 2, 3};
`endif
    sk = '{0, 2, 1, 3};
    scenario(40, 0, -1, 1, 0, 0, 0, 1, 0);

    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < LANE_N; p++) sk[p] = $urandom_range(MAXS, 0);
      scenario(40, 1, -1, 0, 0, 0, 0, 1, r % 2);
    end

    sk = '{0, 9, 0, 0};
    scenario(12, 0, -1, 0, 1, 1, 0, 0, 0);

    sk = '{1, 0, 2, 3};
    scenario(13, 0, 5, 0, 0, 0, 1, 0, 1);

`ifdef LANE_REORDER_EN
    ids = '{1, 1, 2, 3};
    sk  = '{0, 0, 0, 0};
    scenario(6, 0, -1, 0, 0, 0, 1, 0, 0);
    ids = '{2, 0, 3, 1};
`endif

    sk = '{3, 1, 0, 2};
    scenario(20, 1, -1, 0, 0, 0, 0, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deskew_reorder_rx.md
DESKEW_REORDER_RX -- requirements
Module: deskew_reorder_rx
Interface
REQ-001 SHALL have parameter LANE_N, default 4, number of physical/logical lanes.
REQ-002 SHALL have parameter BLOCK_W, default 66, block width including sync header.
REQ-003 SHALL have parameter MAX_SKEW_BLOCK_N, default 8, max tolerated skew in blocks; per-lane buffer depth MAX_SKEW_BLOCK_N+1.
REQ-004 SHALL have derived localparam ID_W = $clog2(LANE_N), min 1.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port valid_i  in  LANE_N  per-physical-lane block valid.
REQ-008 SHALL have port am_v_i  in  LANE_N  alignment marker present on lane this cycle.
REQ-009 SHALL have port lock_v_i  in  LANE_N  upstream block+marker lock per lane.
REQ-010 SHALL have port lane_id_i  in  LANE_N*ID_W  logical lane number decoded from marker, sampled when am_v_i.
REQ-011 SHALL have port data_i  in  LANE_N*BLOCK_W  physical lane blocks, lane p at [p*BLOCK_W +: BLOCK_W].
REQ-012 SHALL have port valid_o  out  1  aligned block valid on all lanes.
REQ-013 SHALL have port am_v_o  out  1  aligned markers on all output lanes.
REQ-014 SHALL have port data_o  out  LANE_N*BLOCK_W  deskewed blocks, logical lane k at [k*BLOCK_W +: BLOCK_W].
REQ-015 SHALL have port deskew_lock_o  out  1  aligned state indicator.
REQ-016 SHALL have port skew_err_o  out  1  one-cycle pulse, skew exceeded MAX_SKEW_BLOCK_N.
REQ-017 SHALL have port align_err_o  out  1  one-cycle pulse, duplicate lane id or marker misalignment while locked.
Function
REQ-018 SHALL implement FSM states IDLE, WAIT_AM, ALIGNED.
REQ-019 IDLE -> WAIT_AM when lock_v_i all-ones; any state -> IDLE when any lock_v_i bit low, effective next cycle.
REQ-020 A cycle with valid_i neither all-ones nor all-zeros SHALL be treated as lock loss (-> IDLE); valid cycles below mean valid_i all-ones.
REQ-021 In WAIT_AM, on a lane's first am_v_i the lane SHALL store marker at buffer index 0, capture lane_id_i, set seen flag; later valid blocks write consecutive indices.
REQ-022 In WAIT_AM a shared counter SHALL start at first marker and count valid cycles; if it reaches MAX_SKEW_BLOCK_N+1 before all seen flags set, pulse skew_err_o, clear flags, stay WAIT_AM.
REQ-023 When final seen flag sets (incl. all lanes in same cycle) and ids are distinct, -> ALIGNED; read pointer starts at index 0.
REQ-024 Duplicate captured ids SHALL pulse align_err_o, clear flags, stay WAIT_AM.
REQ-025 Outputs SHALL be registered: first aligned output (markers, am_v_o=1, valid_o=1) one cycle after the final-marker cycle.
REQ-026 In ALIGNED, each valid cycle SHALL write every lane and advance the common read pointer, modulo MAX_SKEW_BLOCK_N+1 wrap-around.
REQ-027 Buffer entries SHALL carry a marker flag; if read entries show flag on some but not all lanes, pulse align_err_o, drop valid_o that cycle, -> WAIT_AM.
REQ-028 deskew_lock_o SHALL be high exactly in ALIGNED; valid_o and am_v_o SHALL be low outside ALIGNED.
REQ-029 data_o SHALL hold last value when valid_o is low.
Reset
REQ-030 On reset: state IDLE, pointers/counter/flags/ids 0, data_o 0, valid_o 0, am_v_o 0, deskew_lock_o 0, skew_err_o 0, align_err_o 0.
REQ-031 reset mid-ALIGNED SHALL take effect next edge, overriding all other events.
Configuration
REQ-032 With LANE_REORDER_EN defined, logical lane k SHALL output the physical lane whose captured id equals k.
REQ-033 Without LANE_REORDER_EN, lane_id_i SHALL be ignored, mapping identity, REQ-024 check removed.
Verification
REQ-034 LANE_N=4, skews {0,2,1,3} cycles, ids identity -> data_o equals markers on all lanes and am_v_o=1 at cycle 4, deskew_lock_o=1.
REQ-035 Skews {0,9} with MAX_SKEW_BLOCK_N=8 -> skew_err_o pulse at cycle 9 after first marker, no lock.
REQ-036 ALIGNED, lock_v_i[2]=0 for one cycle -> deskew_lock_o=0 and valid_o=0 next cycle; relock after new markers.
REQ-037 LANE_REORDER_EN, physical ids {2,0,3,1} -> data_o lane 0 equals physical lane 1 data, lane 2 equals physical lane 0.
REQ-038 Ids {1,1,2,3} -> align_err_o pulse, remain WAIT_AM; marker on lane 3 only while ALIGNED -> align_err_o pulse, deskew_lock_o=0.
